// File: rtl/gelato_ram_pkg.sv
// Shared types and default geometry for the gelato instruction-fetch RAM responder.
package gelato_ram_pkg;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_WORD_WIDTH     = 32;
    localparam int DEF_WORDS_PER_LINE = 8;
    localparam int DEF_MEM_AWIDTH     = 16;

    localparam int LINE_BITS      = DEF_WORD_WIDTH * DEF_WORDS_PER_LINE;
    localparam int LINE_OFF_WIDTH = $clog2(DEF_WORDS_PER_LINE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } ram_state_e;

    function automatic int line_off_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/gelato_line_assembler.sv
// Collects in-order read words into a cache-line buffer; full pulses on the
// cycle whose capture completes the line.
module gelato_line_assembler
    import gelato_ram_pkg::*;
#(
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic                                 mem_rvalid,
    input  logic [WORD_WIDTH-1:0]                mem_rdata,
    output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] line,
    output logic                                 full
);

    localparam int OFF_W = line_off_width(WORDS_PER_LINE);
    localparam int CNT_W = OFF_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_LINE - 1);

    logic [CNT_W-1:0]                     recv_cnt_r;
    logic [WORD_WIDTH*WORDS_PER_LINE-1:0] line_r;

    // Word capture into the line buffer; clear zeroes both buffer and count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recv_cnt_r <= {CNT_W{1'b0}};
            line_r     <= {(WORD_WIDTH*WORDS_PER_LINE){1'b0}};
        end else if (clear) begin
            recv_cnt_r <= {CNT_W{1'b0}};
            line_r     <= {(WORD_WIDTH*WORDS_PER_LINE){1'b0}};
        end else if (mem_rvalid) begin
            line_r[recv_cnt_r[OFF_W-1:0]*WORD_WIDTH +: WORD_WIDTH] <= mem_rdata;
            recv_cnt_r <= recv_cnt_r + CNT_W'(1);
        end else begin
            recv_cnt_r <= recv_cnt_r;
            line_r     <= line_r;
        end
    end

    assign line = line_r;
    assign full = mem_rvalid && (recv_cnt_r == LAST_IDX);

endmodule

// File: rtl/gelato_ram_responder.sv
// Memory-side line-fill responder: one fill in flight, word reads assembled into a line.
// Optional GELATO_RAM_RESP_ERR_EN adds misaligned/out-of-range request errors on resp_err.
module gelato_ram_responder
    import gelato_ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int MEM_AWIDTH     = DEF_MEM_AWIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rdy,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] resp_data,
`ifdef GELATO_RAM_RESP_ERR_EN
    output logic                                 resp_err,
`endif
    output logic                                 mem_req,
    input  logic                                 mem_gnt,
    output logic [MEM_AWIDTH-1:0]                mem_addr,
    input  logic                                 mem_rvalid,
    input  logic [WORD_WIDTH-1:0]                mem_rdata
);

    localparam int OFF_W = line_off_width(WORDS_PER_LINE);
    localparam int CNT_W = OFF_W + 1;
    localparam int TAG_W = MEM_AWIDTH - OFF_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_LINE);

    ram_state_e       state_r;
    logic [TAG_W-1:0] tag_r;
    logic [CNT_W-1:0] issue_cnt_r;
    logic             resp_valid_r;
    logic             resp_err_r;

    logic accept_s;
    logic bad_addr_s;
    logic capture_s;
    logic line_done_s;
    logic mem_req_s;
    logic unused_addr_s;

    assign req_ready = rdy && !rst && (state_r == ST_IDLE);
    assign accept_s  = req_valid && req_ready;
    assign capture_s = mem_rvalid && (state_r == ST_FILL);
    assign mem_req_s = rdy && (state_r == ST_FILL) && (issue_cnt_r < CNT_FULL);

`ifdef GELATO_RAM_RESP_ERR_EN
    assign bad_addr_s = (req_addr[1:0] != 2'b00) ||
                        (req_addr[ADDR_WIDTH-1:MEM_AWIDTH+2] != {(ADDR_WIDTH-MEM_AWIDTH-2){1'b0}});
    assign resp_err   = resp_err_r;
`else
    logic unused_err_s;
    assign bad_addr_s   = 1'b0;
    assign unused_err_s = resp_err_r;
`endif

    // Byte-offset, line-offset and above-memory bits never reach the tag
    assign unused_addr_s = ^{req_addr[ADDR_WIDTH-1:MEM_AWIDTH+2], req_addr[OFF_W+1:0]};

    // Request accept, read issue and response handshake sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            tag_r        <= {TAG_W{1'b0}};
            issue_cnt_r  <= {CNT_W{1'b0}};
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        tag_r       <= req_addr[MEM_AWIDTH+1:OFF_W+2];
                        issue_cnt_r <= {CNT_W{1'b0}};
                        if (bad_addr_s) begin
                            state_r      <= ST_ERR;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (mem_req_s && mem_gnt) begin
                        issue_cnt_r <= issue_cnt_r + CNT_W'(1);
                    end
                    // Final word lands on this edge, so the response shows next cycle
                    if (line_done_s) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                    end
                end
                ST_RESP, ST_ERR: begin
                    if (resp_valid_r && resp_ready && rdy) begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    gelato_line_assembler #(
        .WORD_WIDTH     (WORD_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept_s),
        .mem_rvalid (capture_s),
        .mem_rdata  (mem_rdata),
        .line       (resp_data),
        .full       (line_done_s)
    );

    assign resp_valid = resp_valid_r;
    assign mem_req    = mem_req_s;
    assign mem_addr   = {tag_r, issue_cnt_r[OFF_W-1:0]};

endmodule

// File: doc/gelato_ram_responder.md
# gelato_ram_responder

Memory-side end of the instruction-fetch RAM interface: accepts cache-line fill requests from the L1 instruction cache, reads the line word-by-word from a backing word memory, assembles it, and returns the full line with a valid/ready handshake. Sits between the frontend's instruction cache and the off-chip/SRAM model. One line fill is in flight at a time.

## Interface
- ADDR_WIDTH, 32, byte address width of requests
- WORD_WIDTH, 32, memory word width in bits (byte-addressed, 4 bytes/word)
- WORDS_PER_LINE, 8, words per cache line (power of two, ≥2)
- MEM_AWIDTH, 16, backing memory word-address width (MEM_WORDS = 2**MEM_AWIDTH)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; 0 freezes issue and handshakes
- req_valid  in  1  fill request valid
- req_ready  out  1  responder can accept a request
- req_addr  in  ADDR_WIDTH  byte address of line
- resp_valid  out  1  assembled line valid
- resp_ready  in  1  cache accepts line
- resp_data  out  WORD_WIDTH*WORDS_PER_LINE  line, word i at [i*WORD_WIDTH +: WORD_WIDTH]
- resp_err  out  1  request error (only with GELATO_RAM_RESP_ERR_EN)
- mem_req  out  1  word read request
- mem_gnt  in  1  memory accepts mem_req this cycle
- mem_addr  out  MEM_AWIDTH  word address
- mem_rvalid  in  1  read data valid (in order, ≥1 cycle after grant)
- mem_rdata  in  WORD_WIDTH  read data

## Operation
- States: IDLE, FILL, RESP (+ ERR with macro).
- IDLE: req_ready=rdy. On req_valid&&req_ready: latch base word address = req_addr[MEM_AWIDTH+1:2] with low log2(WORDS_PER_LINE) bits cleared; clear issue_cnt, recv_cnt; → FILL.
- FILL: mem_req=rdy && issue_cnt<WORDS_PER_LINE; mem_addr=base+issue_cnt; issue_cnt++ on mem_req&&mem_gnt. Every mem_rvalid writes mem_rdata to word recv_cnt, recv_cnt++ (captured regardless of rdy). When recv_cnt reaches WORDS_PER_LINE → RESP.
- RESP: resp_valid=1, resp_data stable; on resp_valid&&resp_ready&&rdy → IDLE.
- Counters are log2(WORDS_PER_LINE)+1 bits; base+issue_cnt never carries out of the line (low bits zero).
- mem_rvalid outside FILL is ignored.
- Reset outputs: req_ready=0 during reset, then 1 in IDLE when rdy; resp_valid=0, resp_data=0, resp_err=0, mem_req=0, mem_addr=0; state IDLE.
- Reset mid-fill aborts line; backing memory shares rst and drops outstanding reads.

## Timing
- req_ready deasserts the cycle after acceptance; reasserts the cycle after response handshake.
- Minimum latency (gnt always 1, rvalid one cycle after gnt): accept at cycle 0, mem_req cycles 1..WORDS_PER_LINE, resp_valid at cycle WORDS_PER_LINE+2.
- Back-to-back: next request accepted no earlier than one cycle after resp handshake.
- rdy=0: mem_req low, no state transitions except word capture; handshakes on rdy=0 cycles do not count.
- Last mem_rvalid and transition to RESP in same edge; resp_valid visible next cycle.

## Configuration
- GELATO_RAM_RESP_ERR_EN defined: in IDLE, a request with req_addr[1:0]!=0 or any req_addr bit above MEM_AWIDTH+1 set goes to ERR; no memory access; next cycle resp_valid=1, resp_err=1, resp_data=0, held until resp_ready; → IDLE. resp_err=0 on good lines.
- Undefined: no resp_err port; high and low address bits silently dropped (wrap within memory).

## Structure
- Package gelato_ram_pkg: state enum, LINE_BITS = WORD_WIDTH*WORDS_PER_LINE, line offset width constant.
- Sub-module gelato_line_assembler: recv counter + line buffer, inputs mem_rvalid/mem_rdata/clear, outputs line and full flag.

## Test plan
- Fill, gnt=1, 1-cycle memory with mem[i]=i: req_addr=0x40 → mem_addr 0x10..0x17, resp_valid at cycle 10, word0=0x10, word7=0x17.
- req_addr=0x5C (mid-line) → same base 0x10 line returned; no extra reads.
- Random mem_gnt stalls and 1–4 cycle read latency → words in order, exactly 8 mem_req&&mem_gnt events.
- resp_ready held 0 for 5 cycles → resp_valid/resp_data stable, req_ready=0 throughout; next request accepted one cycle after handshake.
- rst asserted after 3 grants → all outputs 0 immediately, IDLE; fresh request to 0x80 returns correct line.
- With GELATO_RAM_RESP_ERR_EN, req_addr=0x42 → no mem_req, resp_valid with resp_err=1, resp_data=0 one cycle after acceptance.
